noise_gate: RTL and testbench

Stereo-linked noise gate / downward expander for the audio effects chain. It runs on the 11.29 MHz audio clock and processes one left/right sample pair per `sample_valid_in` strobe. It attenuates the signal to silence while the stereo peak stays at or below a threshold. It opens with a programmable attack ramp and holds open for a programmable number of samples. It then closes with a programmable release ramp. It sits before the limiter in the chain and suppresses low-level noise that the limiter does not act on.

---
 rtl/noise_gate.sv | 258 +++++++++++++++++++++++++
 tb/tb_noise_gate.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_gate.sv
// -----------------------------------------------------------------------------
// noise_gate
//
// Stereo-linked noise gate / downward expander. A single gain, shared by both
// channels, is driven by the larger of the two channel magnitudes. The gain
// ramps up (attack) when the peak rises above the threshold. It stays at unity
// while the peak stays high and for a hold period after the peak drops. It then
// ramps down (release) to silence.
//
// Pipeline: edge E (sample_valid_in = 1) latches the dry pair and updates the
// FSM and gain. Edge E+1 registers the scaled wet pair and pulses
// sample_valid_out.
//
// Ports
//   clk_in           audio clock
//   rst_in           asynchronous, active-low reset
//   gate_enable      1 = gate active, 0 = bypass (wet = dry, FSM held CLOSED)
//   threshold        unsigned magnitude threshold; "above" is peak > threshold
//   attack_step      gain increment per sample in ATTACK (0 = jump to unity)
//   release_step     gain decrement per sample in RELEASE (0 = jump to zero)
//   hold_len         hold time in samples
//   sample_valid_in  one-cycle strobe qualifying data_dry_l / data_dry_r
//   data_dry_l/_r    signed dry samples
//   data_wet_l/_r    signed gated samples, held between strobes
//   sample_valid_out one-cycle strobe qualifying the wet samples
//   gate_open        1 while the FSM is in ATTACK, OPEN, HOLD or RELEASE
// -----------------------------------------------------------------------------
module noise_gate #(
    parameter int WIDTH  = 16,
    parameter int GAIN_W = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     gate_enable,
    input  logic [WIDTH-1:0]         threshold,
    input  logic [GAIN_W-1:0]        attack_step,
    input  logic [GAIN_W-1:0]        release_step,
    input  logic [15:0]              hold_len,
    input  logic                     sample_valid_in,
    input  logic signed [WIDTH-1:0]  data_dry_l,
    input  logic signed [WIDTH-1:0]  data_dry_r,
    output logic signed [WIDTH-1:0]  data_wet_l,
    output logic signed [WIDTH-1:0]  data_wet_r,
    output logic                     sample_valid_out,
    output logic                     gate_open
);

    localparam logic [2:0] ST_CLOSED  = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [GAIN_W-1:0] UNITY     = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic [GAIN_W:0]   UNITY_EXT = {1'b0, UNITY};

    // Width of the signed product: dry sample times the zero-extended gain.
    localparam int PW = WIDTH + GAIN_W + 1;

    // -------------------------------------------------------------------------
    // Detector
    // -------------------------------------------------------------------------
    // |x| with the most negative code clamped to the most positive one, so the
    // magnitude always fits in WIDTH-1 bits of range.
    function automatic logic [WIDTH-1:0] sat_mag(input logic signed [WIDTH-1:0] x);
        if (x == {1'b1, {(WIDTH-1){1'b0}}}) begin
            sat_mag = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (x[WIDTH-1]) begin
            sat_mag = -x;
        end else begin
            sat_mag = x;
        end
    endfunction

    logic [WIDTH-1:0] mag_l;
    logic [WIDTH-1:0] mag_r;
    logic [WIDTH-1:0] peak;
    logic             above;

    assign mag_l = sat_mag(data_dry_l);
    assign mag_r = sat_mag(data_dry_r);
    assign peak  = (mag_l > mag_r) ? mag_l : mag_r;
    assign above = (peak > threshold);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]               state_q, state_d;
    logic [GAIN_W-1:0]        gain_q, gain_d;
    logic [15:0]              cnt_q, cnt_d;
    logic                     gate_open_q;
    logic signed [WIDTH-1:0]  dry_l_q, dry_r_q;
    logic                     bypass_q;
    logic                     pend_q;
    logic signed [WIDTH-1:0]  wet_l_q, wet_r_q;
    logic                     valid_out_q;

    // -------------------------------------------------------------------------
    // Gain ramps
    // -------------------------------------------------------------------------
    // The attack sum is one bit wider so a large step cannot wrap past unity.
    logic [GAIN_W:0]   att_sum;
    logic [GAIN_W-1:0] att_gain;
    logic [GAIN_W-1:0] rel_gain;
    logic [16:0]       cnt_inc;

    assign att_sum  = {1'b0, gain_q} + {1'b0, attack_step};
    assign att_gain = ((attack_step == '0) || (att_sum >= UNITY_EXT))
                      ? UNITY : att_sum[GAIN_W-1:0];
    assign rel_gain = ((release_step == '0) || (release_step >= gain_q))
                      ? '0 : (gain_q - release_step);
    assign cnt_inc  = {1'b0, cnt_q} + 17'd1;

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first so that no
    // path leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        cnt_d   = cnt_q;
        if (sample_valid_in) begin
            if (!gate_enable) begin
                state_d = ST_CLOSED;
                gain_d  = '0;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_CLOSED: begin
                        if (above) begin
                            gain_d  = att_gain;
                            state_d = (att_gain == UNITY) ? ST_OPEN : ST_ATTACK;
                        end
                    end
                    ST_ATTACK: begin
                        // Attack runs to completion regardless of the detector.
                        gain_d  = att_gain;
                        state_d = (att_gain == UNITY) ? ST_OPEN : ST_ATTACK;
                    end
                    ST_OPEN: begin
                        gain_d = UNITY;
                        cnt_d  = '0;
                        if (!above) begin
                            if (hold_len == 16'd0) begin
                                state_d = ST_RELEASE;
                            end else begin
                                state_d = ST_HOLD;
                                cnt_d   = 16'd1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        gain_d = UNITY;
                        if (above) begin
                            state_d = ST_OPEN;
                            cnt_d   = '0;
                        end else if (cnt_inc >= {1'b0, hold_len}) begin
                            // ">=" keeps the hold finite if hold_len is lowered
                            // below the running count mid-hold.
                            state_d = ST_RELEASE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc[15:0];
                        end
                    end
                    ST_RELEASE: begin
                        if (above) begin
                            gain_d  = att_gain;
                            state_d = (att_gain == UNITY) ? ST_OPEN : ST_ATTACK;
                        end else begin
                            gain_d = rel_gain;
                            if (rel_gain == '0) begin
                                state_d = ST_CLOSED;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_CLOSED;
                        gain_d  = '0;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Edge E: FSM, gain, hold counter and dry-sample capture
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of block order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_CLOSED;
            gain_q      <= '0;
            cnt_q       <= '0;
            gate_open_q <= 1'b0;
            dry_l_q     <= '0;
            dry_r_q     <= '0;
            bypass_q    <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            cnt_q       <= cnt_d;
            gate_open_q <= (state_d != ST_CLOSED);
            pend_q      <= sample_valid_in;
            if (sample_valid_in) begin
                dry_l_q  <= data_dry_l;
                dry_r_q  <= data_dry_r;
                bypass_q <= !gate_enable;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Multiply: wet = (dry * {0, gain}) >>> (GAIN_W-1)
    // -------------------------------------------------------------------------
    // Both operands are extended to the full product width so the multiply is
    // exact; selecting bits [GAIN_W-1 +: WIDTH] is the arithmetic shift with
    // truncation toward -inf.
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod_l;
    logic signed [PW-1:0] prod_r;

    assign gain_ext = $signed({{(WIDTH+1){1'b0}}, gain_q});
    assign prod_l   = $signed({{(GAIN_W+1){dry_l_q[WIDTH-1]}}, dry_l_q}) * gain_ext;
    assign prod_r   = $signed({{(GAIN_W+1){dry_r_q[WIDTH-1]}}, dry_r_q}) * gain_ext;

    // Discarded fraction and guard bits of the products.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{prod_l[GAIN_W-2:0], prod_l[PW-1:PW-2],
                                prod_r[GAIN_W-2:0], prod_r[PW-1:PW-2]};

    // -------------------------------------------------------------------------
    // Edge E+1: wet output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wet_l_q     <= '0;
            wet_r_q     <= '0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= pend_q;
            if (pend_q) begin
                wet_l_q <= bypass_q ? dry_l_q : prod_l[GAIN_W-1 +: WIDTH];
                wet_r_q <= bypass_q ? dry_r_q : prod_r[GAIN_W-1 +: WIDTH];
            end
        end
    end

    assign data_wet_l       = wet_l_q;
    assign data_wet_r       = wet_r_q;
    assign sample_valid_out = valid_out_q;
    assign gate_open        = gate_open_q;

endmodule

// File: tb/tb_noise_gate.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_noise_gate
//
// Self-checking bench for noise_gate. Each scenario task drives samples and
// pushes the expected wet pair onto a scoreboard queue; a monitor pops and
// compares whenever sample_valid_out is seen. Scenario tasks also check
// gate_open and strobe timing inline.
// -----------------------------------------------------------------------------
module tb_noise_gate;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        gate_enable = 1'b0;
    logic [15:0] threshold = 16'd1000;
    logic [15:0] attack_step = 16'd8192;
    logic [15:0] release_step = 16'd16384;
    logic [15:0] hold_len = 16'd3;
    logic        sample_valid_in = 1'b0;
    logic [15:0] data_dry_l = '0;
    logic [15:0] data_dry_r = '0;
    logic [15:0] data_wet_l;
    logic [15:0] data_wet_r;
    logic        sample_valid_out;
    logic        gate_open;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];

    noise_gate #(.WIDTH(16), .GAIN_W(16)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .gate_enable      (gate_enable),
        .threshold        (threshold),
        .attack_step      (attack_step),
        .release_step     (release_step),
        .hold_len         (hold_len),
        .sample_valid_in  (sample_valid_in),
        .data_dry_l       (data_dry_l),
        .data_dry_r       (data_dry_r),
        .data_wet_l       (data_wet_l),
        .data_wet_r       (data_wet_r),
        .sample_valid_out (sample_valid_out),
        .gate_open        (gate_open)
    );

    // ~11.29 MHz audio clock
    always #44 clk_in = ~clk_in;

    // Scoreboard monitor: every output strobe must match the oldest expectation.
    always @(negedge clk_in) begin
        if (rst_in && sample_valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected output strobe wet=%h/%h, no sample pending",
                         data_wet_l, data_wet_r);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({data_wet_l, data_wet_r} !== e) begin
                    errors++;
                    $display("FAIL scoreboard: wet L/R=%h/%h expected %h/%h",
                             data_wet_l, data_wet_r, e[31:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Queue an expectation and drive one strobe; returns on the negedge after
    // the strobe edge, where gate_open already reflects that sample.
    task automatic send(input logic [15:0] l, input logic [15:0] r,
                        input logic [15:0] el, input logic [15:0] er);
        @(negedge clk_in);
        exp_q.push_back({el, er});
        data_dry_l      = l;
        data_dry_r      = r;
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 16 && exp_q.size() != 0; i++) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d outputs missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_go(input string name, input logic expv);
        checks++;
        if (gate_open !== expv) begin
            errors++;
            $display("FAIL %s gate_open: got %b expected %b", name, gate_open, expv);
        end
    endtask

    // Gate to OPEN regardless of prior state with a single above sample.
    task automatic open_gate();
        logic [15:0] saved;
        saved       = attack_step;
        gate_enable = 1'b1;
        threshold   = 16'd1000;
        attack_step = 16'd0;
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000);
        attack_step = saved;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        checks++;
        if ({data_wet_l, data_wet_r, sample_valid_out, gate_open} !== 34'd0) begin
            errors++;
            $display("FAIL reset outputs: wet=%h/%h valid=%b open=%b expected all 0",
                     data_wet_l, data_wet_r, sample_valid_out, gate_open);
        end
        rst_in = 1'b1;
    endtask

    task automatic test_bypass();
        gate_enable = 1'b0;
        @(negedge clk_in);
        exp_q.push_back({16'h1234, 16'h5678});
        data_dry_l      = 16'h1234;
        data_dry_r      = 16'h5678;
        sample_valid_in = 1'b1;
        @(negedge clk_in);  // after E
        sample_valid_in = 1'b0;
        checks++;
        if (sample_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL bypass latency: valid_out=%b after E, expected 0", sample_valid_out);
        end
        @(negedge clk_in);  // after E+1
        checks++;
        if (sample_valid_out !== 1'b1 || data_wet_l !== 16'h1234) begin
            errors++;
            $display("FAIL bypass output: valid_out=%b wet_l=%h expected 1 / 1234",
                     sample_valid_out, data_wet_l);
        end
        @(negedge clk_in);  // after E+2
        checks++;
        if (sample_valid_out !== 1'b0 || data_wet_l !== 16'h1234) begin
            errors++;
            $display("FAIL bypass pulse/hold: valid_out=%b wet_l=%h expected 0 / 1234",
                     sample_valid_out, data_wet_l);
        end
        wait_drain("bypass");
    endtask

    task automatic test_closed();
        gate_enable = 1'b1;
        threshold   = 16'd1000;
        send(16'd500,  16'hFE0C, 16'h0000, 16'h0000);  // 500 / -500
        check_go("closed_500", 1'b0);
        send(16'd1000, 16'hFC18, 16'h0000, 16'h0000);  // peak exactly 1000
        check_go("closed_eq", 1'b0);
        send(16'h0000, 16'hFC18, 16'h0000, 16'h0000);  // R alone at -1000
        check_go("closed_r", 1'b0);
        wait_drain("closed");
    endtask

    task automatic test_attack();
        logic [15:0] el [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
        logic [15:0] er [4] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFD};
        gate_enable = 1'b1;
        threshold   = 16'd1000;
        attack_step = 16'd8192;
        // R = -3 exercises truncation toward -inf at each fractional gain.
        for (int i = 0; i < 4; i++) begin
            send(16'h4000, 16'hFFFD, el[i], er[i]);
            check_go("attack", 1'b1);
        end
        // Bypass sample forces CLOSED, then an instant attack.
        gate_enable = 1'b0;
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000);
        check_go("attack_bypass", 1'b0);
        gate_enable = 1'b1;
        attack_step = 16'd0;
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000);
        check_go("attack_instant", 1'b1);
        attack_step = 16'd8192;
        wait_drain("attack");
    endtask

    task automatic test_hold_release();
        logic [15:0] e3 [5] = '{16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0000};
        logic        g3 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] e0 [3] = '{16'h0100, 16'h0080, 16'h0000};
        logic        g0 [3] = '{1'b1, 1'b1, 1'b0};
        release_step = 16'd16384;
        hold_len     = 16'd3;
        open_gate();
        for (int i = 0; i < 5; i++) begin
            send(16'h0100, 16'h0000, e3[i], 16'h0000);
            check_go("hold3", g3[i]);
        end
        hold_len = 16'd0;
        open_gate();
        for (int i = 0; i < 3; i++) begin
            send(16'h0100, 16'h0000, e0[i], 16'h0000);
            check_go("hold0", g0[i]);
        end
        wait_drain("hold_release");
    endtask

    task automatic test_retrigger();
        hold_len     = 16'd0;
        release_step = 16'd16384;
        attack_step  = 16'd8192;
        open_gate();
        send(16'h0100, 16'h0000, 16'h0100, 16'h0000);  // OPEN -> RELEASE
        send(16'h0100, 16'h0000, 16'h0080, 16'h0000);  // gain 16384
        // -32768 saturates to 32767 > 32766: retrigger, gain 24576.
        threshold = 16'd32766;
        send(16'h0100, 16'h8000, 16'h00C0, 16'hA000);
        check_go("retrigger", 1'b1);
        // Below sample: attack continues to unity.
        send(16'h0100, 16'h0000, 16'h0100, 16'h0000);
        send(16'h0100, 16'h0000, 16'h0100, 16'h0000);  // OPEN -> RELEASE
        send(16'h0100, 16'h0000, 16'h0080, 16'h0000);  // gain 16384
        // Saturated 32767 is not above 32767: release continues to silence.
        threshold = 16'd32767;
        send(16'h0100, 16'h8000, 16'h0000, 16'h0000);
        check_go("sat_peak", 1'b0);
        threshold = 16'd1000;
        wait_drain("retrigger");
    endtask

    task automatic test_hold_restart();
        logic [15:0] e [5] = '{16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0000};
        hold_len     = 16'd3;
        release_step = 16'd16384;
        open_gate();
        send(16'h0100, 16'h0000, 16'h0100, 16'h0000);  // HOLD cnt 1
        send(16'h0100, 16'h0000, 16'h0100, 16'h0000);  // HOLD cnt 2
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000);  // above: back to OPEN
        for (int i = 0; i < 5; i++) begin
            send(16'h0100, 16'h0000, e[i], 16'h0000);
        end
        check_go("hold_restart", 1'b0);
        wait_drain("hold_restart");
    endtask

    task automatic test_back_to_back();
        int seen;
        gate_enable = 1'b0;
        seen = 0;
        @(negedge clk_in);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back({16'(i), 16'(16'd0 - 16'(i))});
            data_dry_l      = 16'(i);
            data_dry_r      = 16'(16'd0 - 16'(i));
            sample_valid_in = 1'b1;
            @(negedge clk_in);
            if (sample_valid_out) seen++;
        end
        sample_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            if (sample_valid_out) seen++;
        end
        checks++;
        if (seen != 4) begin
            errors++;
            $display("FAIL back_to_back strobes: got %0d expected 4", seen);
        end
        wait_drain("back_to_back");
        gate_enable = 1'b1;
    endtask

    task automatic test_reset_strobe();
        int seen;
        seen = 0;
        gate_enable = 1'b0;
        @(negedge clk_in);
        data_dry_l      = 16'h7777;
        data_dry_r      = 16'h1111;
        sample_valid_in = 1'b1;
        @(negedge clk_in);  // sample latched at E; reset before E+1
        sample_valid_in = 1'b0;
        rst_in          = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            if (i == 2) rst_in = 1'b1;
            if (sample_valid_out) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_strobe: got %0d output strobes expected 0", seen);
        end
        gate_enable = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        hold_len = 16'd3;
        open_gate();
        wait_drain("reset_mid_pre");
        check_go("reset_mid_pre", 1'b1);
        #3;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({data_wet_l, data_wet_r, sample_valid_out, gate_open} !== 34'd0) begin
            errors++;
            $display("FAIL reset_async: wet=%h/%h valid=%b open=%b expected all 0",
                     data_wet_l, data_wet_r, sample_valid_out, gate_open);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        // State must be CLOSED again: a below sample is silenced.
        send(16'd500, 16'h0000, 16'h0000, 16'h0000);
        check_go("reset_mid_closed", 1'b0);
        wait_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_closed();
        test_attack();
        test_hold_release();
        test_retrigger();
        test_hold_restart();
        test_back_to_back();
        test_reset_strobe();
        test_reset_mid_run();
        repeat (4) @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
